hazard_ctrl: RTL and testbench

//  Issue/stall controller for the decode stage. Keeps a scoreboard of register

---
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl.sv | 109 ++++++++++
 tb/tb_hazard_ctrl.sv | 119 +++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl_if : decode-stage issue/stall handshake bundle            |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [2:0]       id_rs_sel;
  logic             id_rs_used;
  logic [2:0]       id_rt_sel;
  logic             id_rt_used;
  logic [2:0]       id_wr_sel;
  logic             id_wr_en;
  logic             id_halt;
  logic             ex_flush;
  logic             stall;
  logic             issue;
  logic             bubble;
  logic             halted;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  modport master (
    output id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_sel, id_wr_en, id_halt, ex_flush,
    input  stall, issue, bubble, halted, busy, stall_count
  );

  modport slave (
    input  id_valid, id_rs_sel, id_rs_used, id_rt_sel, id_rt_used,
           id_wr_sel, id_wr_en, id_halt, ex_flush,
    output stall, issue, bubble, halted, busy, stall_count
  );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_ctrl : decode-stage RAW stall, branch kill and halt sequencer  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module hazard_ctrl #(
  parameter int DEPTH = 3,
  parameter int CNT_W = 16
) (
  input  wire logic     clk,
  input  wire logic     rst,
  hazard_ctrl_if.slave  bus
);
  localparam int DC_W = $clog2(DEPTH + 1);

  localparam logic [1:0] S_RUN    = 2'd0;
  localparam logic [1:0] S_DRAIN  = 2'd1;
  localparam logic [1:0] S_HALTED = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [DC_W-1:0]  drain_cnt;
  logic [DEPTH-1:0] sb_v;
  logic [2:0]       sb_sel [DEPTH];
  logic [DEPTH-2:0] rs_hit;
  logic [DEPTH-2:0] rt_hit;
  logic             hazard;
  logic             stall_c;
  logic             issue_c;
  logic             bubble_c;
  logic [CNT_W-1:0] stall_cnt;

  // WB (last entry) is bypassed by the register file, so it never matches.
  for (genvar i = 0; i < DEPTH - 1; i++) begin : g_match
    assign rs_hit[i] = sb_v[i] && (sb_sel[i] == bus.id_rs_sel);
    assign rt_hit[i] = sb_v[i] && (sb_sel[i] == bus.id_rt_sel);
  end

  assign hazard = bus.id_valid &&
                  ((bus.id_rs_used && |rs_hit) || (bus.id_rt_used && |rt_hit));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sb_v[i]   <= 1'b0;
        sb_sel[i] <= 3'd0;
      end
    end else begin
      sb_v[0]   <= issue_c && bus.id_wr_en;
      sb_sel[0] <= bus.id_wr_sel;
      for (int i = 1; i < DEPTH; i++) begin
        sb_v[i]   <= sb_v[i-1];
        sb_sel[i] <= sb_sel[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_RUN;
    else     state <= state_nxt;
  end

  // Transition on the clock where the counter steps down to 1, so HALTED
  // is reached DEPTH cycles after the HALT issues.
  always_comb begin
    state_nxt = state;
    case (state)
      S_RUN:   if (issue_c && bus.id_halt) state_nxt = S_DRAIN;
      S_DRAIN: if (drain_cnt <= DC_W'(2))  state_nxt = S_HALTED;
      default: state_nxt = S_HALTED;
    endcase
  end

  always_comb begin
    stall_c  = 1'b0;
    issue_c  = 1'b0;
    bubble_c = 1'b0;
    if (rst) begin
      stall_c = 1'b0;
    end else if (bus.ex_flush) begin
      bubble_c = 1'b1;
    end else if (state != S_RUN || hazard) begin
      stall_c  = 1'b1;
      bubble_c = 1'b1;
    end else begin
      issue_c  = bus.id_valid;
      bubble_c = !bus.id_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                                 drain_cnt <= '0;
    else if (state == S_RUN && issue_c && bus.id_halt) drain_cnt <= DC_W'(DEPTH);
    else if (state == S_DRAIN)               drain_cnt <= drain_cnt - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                          stall_cnt <= '0;
    else if (stall_c && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
  end

  assign bus.stall       = stall_c;
  assign bus.issue       = issue_c;
  assign bus.bubble      = bubble_c;
  assign bus.halted      = (state == S_HALTED);
  assign bus.busy        = |sb_v;
  assign bus.stall_count = stall_cnt;
endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_hazard_ctrl : randomized bench against a cycle-history model       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module tb_hazard_ctrl;
  localparam int DEPTH  = 3;
  localparam int CNT_W  = 4;
  localparam int CYCLES = 3000;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  hazard_ctrl_if #(.CNT_W(CNT_W)) bus ();

  hazard_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
  endtask

  // Model: write log indexed by cycles since reset; index holds {valid, sel}
  // of the write issued in that cycle.
  logic [3:0] wlog [4096];
  int         n;
  int         halt_cyc;
  int         cnt;

  initial begin
    logic e_stall, e_issue, e_bubble, e_haz, e_busy, e_halted;
    n_checks = 0;
    n_pass   = 0;
    n        = 0;
    halt_cyc = -1;
    cnt      = 0;
    rst      = 1'b1;
    bus.id_valid = 0; bus.id_rs_sel = 0; bus.id_rs_used = 0;
    bus.id_rt_sel = 0; bus.id_rt_used = 0; bus.id_wr_sel = 0;
    bus.id_wr_en = 0; bus.id_halt = 0; bus.ex_flush = 0;

    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      if (cyc < 2 || n > 4000)
        rst = 1'b1;
      else if (halt_cyc >= 0 && n >= halt_cyc + DEPTH + 6)
        rst = 1'b1;
      else if (halt_cyc >= 0)
        rst = ($urandom_range(0, 11) == 0);
      else
        rst = ($urandom_range(0, 199) == 0);

      bus.id_valid   = ($urandom_range(0, 7) != 0);
      bus.id_rs_sel  = 3'($urandom_range(0, 3));
      bus.id_rs_used = ($urandom_range(0, 3) != 0);
      bus.id_rt_sel  = 3'($urandom_range(0, 3));
      bus.id_rt_used = ($urandom_range(0, 1) != 0);
      bus.id_wr_sel  = 3'($urandom_range(0, 3));
      bus.id_wr_en   = ($urandom_range(0, 3) != 0);
      bus.id_halt    = ($urandom_range(0, 59) == 0);
      bus.ex_flush   = ($urandom_range(0, 7) == 0);

      @(negedge clk);
      e_haz  = 1'b0;
      e_busy = 1'b0;
      for (int k = 1; k <= DEPTH; k++) begin
        if (n - k >= 0 && wlog[n-k][3]) begin
          e_busy = 1'b1;
          if (k < DEPTH && bus.id_valid &&
              ((bus.id_rs_used && wlog[n-k][2:0] == bus.id_rs_sel) ||
               (bus.id_rt_used && wlog[n-k][2:0] == bus.id_rt_sel)))
            e_haz = 1'b1;
        end
      end
      e_halted = (halt_cyc >= 0) && (n >= halt_cyc + DEPTH);
      e_stall  = 1'b0;
      e_issue  = 1'b0;
      e_bubble = 1'b0;
      if (!rst) begin
        if (bus.ex_flush)              e_bubble = 1'b1;
        else if (halt_cyc >= 0 || e_haz) begin e_stall = 1'b1; e_bubble = 1'b1; end
        else begin e_issue = bus.id_valid; e_bubble = !bus.id_valid; end
      end

      check("stall",       bus.stall,       e_stall);
      check("issue",       bus.issue,       e_issue);
      check("bubble",      bus.bubble,      e_bubble);
      check("halted",      bus.halted,      e_halted);
      check("busy",        bus.busy,        e_busy);
      check("stall_count", bus.stall_count, cnt);

      @(posedge clk);
      if (rst) begin
        n        = 0;
        halt_cyc = -1;
        cnt      = 0;
      end else begin
        wlog[n] = {e_issue && bus.id_wr_en, bus.id_wr_sel};
        if (e_issue && bus.id_halt && halt_cyc < 0) halt_cyc = n;
        if (e_stall && cnt < (1 << CNT_W) - 1) cnt++;
        n++;
      end
      #1;
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
`default_nettype wire
